// File: rtl/point_pixel_responder.sv
// Answers black/white point queries from the circle decoder by reading one frame-buffer pixel.
// Ports: pt_req/location_x/location_y in, Ans_valid/pt_pixl_value/oob/err_timeout/resp_cnt out, mem_rd_* to the arbiter.
module point_pixel_responder #(
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int PIX_THRESH = 128,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pt_req,
  input  logic [9:0]  location_x,
  input  logic [9:0]  location_y,
  output logic        Ans_valid,
  output logic        pt_pixl_value,
  output logic        mem_rd_req,
  output logic [18:0] mem_rd_addr,
  input  logic        mem_rd_grant,
  input  logic        mem_rd_valid,
  input  logic [7:0]  mem_rd_data,
  output logic        oob,
  output logic        err_timeout,
  output logic [15:0] resp_cnt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [10:0] W_LIM = 11'(IMG_W);
  localparam logic [10:0] H_LIM = 11'(IMG_H);
  localparam logic [8:0]  THR   = 9'(PIX_THRESH);

  typedef enum logic [2:0] {
    IDLE, ADDR, REQ, WAIT, RESP, DROP
  } state_e;

  state_e        state_q;
  logic [9:0]    x_q, y_q;
  logic [TW-1:0] tmo_q;
  logic [18:0]   addr_q;
  logic [15:0]   cnt_q;
  logic          ans_q, pix_q, req_q, oob_q, err_q;

  logic          oob_d;
  logic [18:0]   addr_d;
  logic          tmo_hit;

  assign oob_d   = ({1'b0, x_q} >= W_LIM)
                || ({1'b0, y_q} >= H_LIM);
  assign addr_d  = 19'(y_q) * 19'(IMG_W) + 19'(x_q);
  // Last cycle of the REQ+WAIT budget; wins over grant/valid.
  assign tmo_hit = (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      tmo_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
      ans_q   <= 1'b0;
      pix_q   <= 1'b0;
      req_q   <= 1'b0;
      oob_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ans_q <= 1'b0;
      oob_q <= 1'b0;
      err_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (pt_req) begin
            x_q     <= location_x;
            y_q     <= location_y;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          tmo_q <= '0;
          if (oob_d) begin
            ans_q   <= 1'b1;
            oob_q   <= 1'b1;
            pix_q   <= 1'b0;
            state_q <= RESP;
          end else begin
            addr_q  <= addr_d;
            req_q   <= 1'b1;
            state_q <= REQ;
          end
        end
        REQ: begin
          tmo_q <= tmo_q + TW'(1);
          if (tmo_hit) begin
            req_q   <= 1'b0;
            ans_q   <= 1'b1;
            err_q   <= 1'b1;
            pix_q   <= 1'b0;
            state_q <= RESP;
          end else if (mem_rd_grant) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          tmo_q <= tmo_q + TW'(1);
          if (tmo_hit) begin
            ans_q   <= 1'b1;
            err_q   <= 1'b1;
            pix_q   <= 1'b0;
            state_q <= RESP;
          end else if (mem_rd_valid) begin
            ans_q   <= 1'b1;
            pix_q   <= ({1'b0, mem_rd_data} < THR);
            state_q <= RESP;
          end
        end
        RESP: begin
          cnt_q   <= cnt_q + 16'd1;
          state_q <= DROP;
        end
        DROP: begin
          // Wait for the decoder to release pt_req so one request gets one answer.
          if (!pt_req) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Ans_valid     = ans_q;
  assign pt_pixl_value = pix_q;
  assign mem_rd_req    = req_q;
  assign mem_rd_addr   = addr_q;
  assign oob           = oob_q;
  assign err_timeout   = err_q;
  assign resp_cnt      = cnt_q;

endmodule

// File: tb/tb_point_pixel_responder.sv
// Randomized bench for point_pixel_responder against a transaction-level model.
// Model predicts address, answer, flags, latency and answer count per request.
module tb_point_pixel_responder;

  localparam int W   = 640;
  localparam int H   = 480;
  localparam int TH  = 128;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pt_req;
  logic [9:0]  lx, ly;
  logic        Ans_valid, pt_pixl_value, mem_rd_req;
  logic [18:0] mem_rd_addr;
  logic        mem_rd_grant, mem_rd_valid;
  logic [7:0]  mem_rd_data;
  logic        oob, err_timeout;
  logic [15:0] resp_cnt;

  int checks = 0;
  int fails  = 0;
  int cnt_m  = 0;

  point_pixel_responder #(
    .IMG_W(W), .IMG_H(H), .PIX_THRESH(TH), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pt_req(pt_req),
    .location_x(lx),
    .location_y(ly),
    .Ans_valid(Ans_valid),
    .pt_pixl_value(pt_pixl_value),
    .mem_rd_req(mem_rd_req),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_grant(mem_rd_grant),
    .mem_rd_valid(mem_rd_valid),
    .mem_rd_data(mem_rd_data),
    .oob(oob),
    .err_timeout(err_timeout),
    .resp_cnt(resp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got,
                     input longint exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ans"}, Ans_valid, 0);
    chk({tag, "_pix"}, pt_pixl_value, 0);
    chk({tag, "_req"}, mem_rd_req, 0);
    chk({tag, "_oob"}, oob, 0);
    chk({tag, "_err"}, err_timeout, 0);
    chk({tag, "_addr"}, mem_rd_addr, 0);
    chk({tag, "_cnt"}, resp_cnt, 0);
  endtask

  // g: grant delay in requested cycles, k: data delay after grant,
  // hold: cycles pt_req stays high after the answer.
  task automatic txn(input int x, input int y, input int g,
                     input int k, input logic [7:0] d,
                     input int hold, input bit early,
                     input bit nogrant);
    int eo, ep, ee, ea, elat, ereq;
    int n, req_n, ans_n, ans_cnt, gw, req_after;
    int got_oob, got_err, got_pix, addr_bad;
    bit granted, prev_g;
    eo   = (x >= W || y >= H) ? 1 : 0;
    ee   = (!eo && nogrant) ? 1 : 0;
    ea   = y * W + x;
    ep   = (eo || ee) ? 0 : ((d < TH) ? 1 : 0);
    elat = eo ? 2 : (ee ? 2 + TMO : 3 + g + k);
    ereq = eo ? 0 : (ee ? TMO : g + 1);
    n = 0; req_n = 0; ans_n = 0; ans_cnt = 0; gw = 0;
    req_after = 0; addr_bad = 0;
    got_oob = 0; got_err = 0; got_pix = 0;
    granted = 0; prev_g = 0;
    pt_req = 1'b1;
    lx = 10'(x);
    ly = 10'(y);
    while (1) begin
      tick();
      n++;
      if (Ans_valid) begin
        ans_cnt++;
        if (ans_n == 0) begin
          ans_n   = n;
          got_oob = oob;
          got_err = err_timeout;
          got_pix = pt_pixl_value;
          cnt_m   = (cnt_m + 1) % 65536;
        end
      end
      if (mem_rd_req) begin
        if (ans_n != 0) req_after++;
        else req_n++;
        if (mem_rd_addr != 19'(ea)) addr_bad = 1;
      end
      if (prev_g && !mem_rd_req && !granted) granted = 1;
      mem_rd_grant = 1'b0;
      mem_rd_valid = 1'b0;
      mem_rd_data  = 8'($urandom);
      if (ans_n != 0) begin
        if (n == ans_n + 1) begin
          mem_rd_grant = 1'b1;
          mem_rd_valid = 1'b1;
          mem_rd_data  = 8'h00;
        end
      end else if (granted) begin
        gw++;
        if (gw == k) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = d;
        end
      end else begin
        if (mem_rd_req && !nogrant && req_n > g)
          mem_rd_grant = 1'b1;
        if ($urandom_range(0, 3) == 0) begin
          mem_rd_valid = 1'b1;
          mem_rd_data  = 8'h00;
        end
      end
      prev_g = mem_rd_grant;
      if (early && n == 1) pt_req = 1'b0;
      if (ans_n != 0 && n == ans_n + hold) pt_req = 1'b0;
      if (ans_n != 0 && n >= ans_n + hold + 3) break;
      if (n >= 600) break;
    end
    pt_req       = 1'b0;
    mem_rd_grant = 1'b0;
    mem_rd_valid = 1'b0;
    chk("ans_count", ans_cnt, 1);
    chk("latency", ans_n, elat);
    chk("oob_flag", got_oob, eo);
    chk("err_flag", got_err, ee);
    chk("pixel", got_pix, ep);
    chk("req_cycles", req_n, ereq);
    chk("addr_bad", addr_bad, 0);
    chk("req_after", req_after, 0);
    chk("pix_hold", pt_pixl_value, ep);
    chk("flags_idle", {oob, err_timeout, Ans_valid}, 0);
    chk("resp_cnt", resp_cnt, cnt_m);
    tick();
    tick();
  endtask

  task automatic reset_mid();
    int a, r;
    pt_req = 1'b1;
    lx = 10'd5;
    ly = 10'd5;
    for (int i = 1; i <= 3; i++) begin
      tick();
      mem_rd_grant = (i == 2) ? 1'b1 : 1'b0;
    end
    chk("pre_rst_req", mem_rd_req, 0);
    #2;
    rst_n  = 1'b0;
    pt_req = 1'b0;
    #1;
    chk_zero("rst_mid");
    cnt_m = 0;
    tick();
    rst_n        = 1'b1;
    mem_rd_valid = 1'b1;
    mem_rd_data  = 8'h00;
    a = 0;
    r = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      mem_rd_valid = 1'b0;
      if (Ans_valid) a++;
      if (mem_rd_req) r++;
    end
    chk("rst_no_ans", a, 0);
    chk("rst_no_req", r, 0);
  endtask

  initial begin
    int x, y;
    rst_n        = 1'b0;
    pt_req       = 1'b0;
    lx           = '0;
    ly           = '0;
    mem_rd_grant = 1'b0;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    repeat (3) tick();
    chk_zero("reset");
    rst_n = 1'b1;
    tick();

    txn(10, 2, 0, 2, 8'h20, 0, 0, 0);
    chk("first_addr_cnt", resp_cnt, 1);
    txn(639, 479, 0, 1, 8'hC8, 0, 0, 0);
    txn(640, 0, 0, 1, 8'h00, 0, 0, 0);
    txn(0, 480, 0, 1, 8'h00, 1, 0, 0);
    txn(1, 1, 0, 1, 8'd127, 0, 0, 0);
    txn(2, 1, 1, 1, 8'd128, 0, 0, 0);
    txn(100, 100, 0, 1, 8'h00, 0, 0, 1);
    txn(3, 4, 0, 1, 8'h10, 5, 0, 0);
    txn(7, 9, 2, 3, 8'h05, 0, 1, 0);
    txn(1023, 1023, 0, 1, 8'h00, 2, 0, 0);

    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 4) == 0) begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(H, 1023);
      end else begin
        x = $urandom_range(0, W - 1);
        y = $urandom_range(0, H - 1);
      end
      txn(x, y, $urandom_range(0, 4), $urandom_range(1, 4),
          8'($urandom), $urandom_range(0, 3),
          $urandom_range(0, 7) == 0, 0);
    end

    reset_mid();
    txn(20, 30, 0, 2, 8'h01, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
